// File: rtl/plu_pkg.sv
// Shared types and constants for the PLU pipeline controller.
package plu_pkg;

  typedef enum logic [1:0] {
    NOWGT = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } plu_state_e;

  localparam int PLU_STAGES = 4;

  // Stage indices: operand regs, products, partial sums, ReLU output.
  localparam int STG_OPND = 0;
  localparam int STG_R1   = 1;
  localparam int STG_R2   = 2;
  localparam int STG_R3   = 3;

endpackage

// File: rtl/plu_pipe_ctrl_if.sv
// Valid/ready handshakes between the PLU controller, the weight/activation source and the result consumer.
interface plu_pipe_ctrl_if;

  logic w_valid;
  logic w_ready;
  logic a_valid;
  logic a_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output w_valid, a_valid, out_ready,
    input  w_ready, a_ready, out_valid
  );

  modport slave (
    input  w_valid, a_valid, out_ready,
    output w_ready, a_ready, out_valid
  );

endinterface

// File: rtl/plu_stage_vld.sv
// One pipeline-stage valid flag; adv says the stage can take a new entry this cycle.
module plu_stage_vld (
  input  logic clk,
  input  logic rst_n,
  input  logic load_en,
  input  logic drain_en,
  input  logic flush,
  output logic v,
  output logic adv
);

  assign adv = !v | drain_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else begin
      v <= load_en | (v & !drain_en);
    end
  end

endmodule

// File: rtl/plu_pipe_ctrl.sv
// Sequencer for the 4-stage PLU datapath: weight-load FSM plus valid-bit pipeline with backpressure.
// Optional perf counters (result_cnt, stall_cnt) are built only when PLU_CTRL_PERF_EN is defined.
module plu_pipe_ctrl
  import plu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  plu_pipe_ctrl_if.slave  bus,
  input  logic            flush,
  output logic            w_we,
  output logic            a_we,
  output logic            r1_we,
  output logic            r2_we,
  output logic            r3_we,
  output logic            busy
`ifdef PLU_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] result_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  plu_state_e state, state_nxt;
  logic       w_ready;
  logic       v0, v1, v2, v3;
  logic       adv0, adv1, adv2, adv3;

  // Enables ripple back from the consumer; flush suppresses every move.
  assign r3_we = v2 & adv3 & !flush;
  assign r2_we = v1 & adv2 & !flush;
  assign r1_we = v0 & adv1 & !flush;

  assign bus.a_ready   = (state == RUN) & !bus.w_valid & !flush & adv0;
  assign a_we          = bus.a_valid & bus.a_ready;
  assign bus.w_ready   = w_ready;
  assign bus.out_valid = v3;
  assign busy          = v0 | v1 | v2 | v3 | (state != RUN);

  plu_stage_vld u_stg_opnd (
    .clk(clk), .rst_n(rst_n), .load_en(a_we),  .drain_en(r1_we),
    .flush(flush), .v(v0), .adv(adv0)
  );

  plu_stage_vld u_stg_r1 (
    .clk(clk), .rst_n(rst_n), .load_en(r1_we), .drain_en(r2_we),
    .flush(flush), .v(v1), .adv(adv1)
  );

  plu_stage_vld u_stg_r2 (
    .clk(clk), .rst_n(rst_n), .load_en(r2_we), .drain_en(r3_we),
    .flush(flush), .v(v2), .adv(adv2)
  );

  plu_stage_vld u_stg_r3 (
    .clk(clk), .rst_n(rst_n), .load_en(r3_we), .drain_en(bus.out_ready),
    .flush(flush), .v(v3), .adv(adv3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NOWGT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaults come first so every path assigns every output (no latches).
  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    w_we      = 1'b0;
    case (state)
      NOWGT: begin
        w_ready = !flush;
        if (bus.w_valid && w_ready) begin
          w_we      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.w_valid && !flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        // R3 is already past the weights, so only the first three stages must empty.
        w_ready = !flush & !v0 & !v1 & !v2;
        if (bus.w_valid && w_ready) begin
          w_we      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = NOWGT;
    endcase
  end

`ifdef PLU_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (v3 && bus.out_ready && (result_cnt != '1)) result_cnt <= result_cnt + CNT_W'(1);
      if (v3 && !bus.out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_plu_pipe_ctrl.sv
// Directed bench for plu_pipe_ctrl with a small behavioural PLU datapath driven by the DUT enables.
// Define PLU_CTRL_PERF_EN to also exercise the perf counters (incl. a CNT_W=2 saturation instance).
module tb_plu_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic w_we, a_we, r1_we, r2_we, r3_we, busy;

  plu_pipe_ctrl_if bus ();

  always #5 clk = ~clk;

`ifdef PLU_CTRL_PERF_EN
  logic [15:0] result_cnt, stall_cnt;
  logic [1:0]  sat_result_cnt, sat_stall_cnt;
  logic        s_w_we, s_a_we, s_r1_we, s_r2_we, s_r3_we, s_busy;

  plu_pipe_ctrl_if sat_bus ();
  assign sat_bus.w_valid   = bus.w_valid;
  assign sat_bus.a_valid   = bus.a_valid;
  assign sat_bus.out_ready = bus.out_ready;

  plu_pipe_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .w_we(w_we), .a_we(a_we), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we), .busy(busy),
    .result_cnt(result_cnt), .stall_cnt(stall_cnt)
  );

  plu_pipe_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus), .flush(flush),
    .w_we(s_w_we), .a_we(s_a_we), .r1_we(s_r1_we), .r2_we(s_r2_we), .r3_we(s_r3_we),
    .busy(s_busy), .result_cnt(sat_result_cnt), .stall_cnt(sat_stall_cnt)
  );
`else
  plu_pipe_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .w_we(w_we), .a_we(a_we), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we), .busy(busy)
  );
`endif

  // Behavioural datapath: weights/activations -> products -> pair sums -> ReLU.
  logic signed [7:0]  w_in [4];
  logic signed [7:0]  a_in [4];
  logic signed [7:0]  w_reg [4];
  logic signed [7:0]  a_reg [4];
  logic signed [15:0] r1 [4];
  logic signed [16:0] r2 [2];
  logic signed [17:0] r3;
  wire  signed [17:0] r2_sum = r2[0] + r2[1];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_we)  w_reg[i] <= w_in[i];
      if (a_we)  a_reg[i] <= a_in[i];
      if (r1_we) r1[i]    <= w_reg[i] * a_reg[i];
    end
    if (r2_we) begin
      r2[0] <= r1[0] + r1[1];
      r2[1] <= r1[2] + r1[3];
    end
    if (r3_we) r3 <= (r2_sum < 0) ? '0 : r2_sum;
  end

  int cyc = 0;
  int got[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got.push_back(int'(r3));
      got_cyc.push_back(cyc);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input int x1, input int x2, input int x3, input int x4);
    a_in[0] = 8'(x1); a_in[1] = 8'(x2); a_in[2] = 8'(x3); a_in[3] = 8'(x4);
  endtask

  task automatic set_w(input int x1, input int x2, input int x3, input int x4);
    w_in[0] = 8'(x1); w_in[1] = 8'(x2); w_in[2] = 8'(x3); w_in[3] = 8'(x4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_w(0, 0, 0, 0);
    set_a(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  // No weights loaded yet: activations are refused and nothing moves.
  task automatic test_reset();
    logic [4:0] wes;
    do_reset();
    bus.a_valid = 1'b1;
    set_a(1, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      settle();
      wes = {w_we, a_we, r1_we, r2_we, r3_we};
      n_total++;
      if (bus.a_ready !== 1'b0) $display("FAIL reset_a_ready got=%b exp=0", bus.a_ready);
      else n_pass++;
      n_total++;
      if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy);
      else n_pass++;
      n_total++;
      if (wes !== 5'b0) $display("FAIL reset_we got=%b exp=00000", wes);
      else n_pass++;
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      else n_pass++;
      tick();
    end
    bus.a_valid = 1'b0;
  endtask

  // Weights (1,2,3,4) then three vectors streamed back to back.
  task automatic test_stream();
    int exp_v [3] = '{10, 2, 0};
    int acc_cyc = 0;
    int t = 0;
    bus.w_valid = 1'b1;
    set_w(1, 2, 3, 4);
    settle();
    n_total++;
    if (w_we !== 1'b1) $display("FAIL load_w_we got=%b exp=1", w_we);
    else n_pass++;
    tick();
    bus.w_valid = 1'b0;
    bus.out_ready = 1'b1;
    got.delete();
    got_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      bus.a_valid = 1'b1;
      if (k == 0) set_a(1, 1, 1, 1);
      else if (k == 1) set_a(2, 0, 0, 0);
      else set_a(-5, 0, 0, 0);
      settle();
      if (k == 0) acc_cyc = cyc;
      n_total++;
      if (a_we !== 1'b1) $display("FAIL stream_a_we[%0d] got=%b exp=1", k, a_we);
      else n_pass++;
      tick();
    end
    bus.a_valid = 1'b0;
    while (got.size() < 3 && t < 20) begin
      tick();
      t++;
    end
    n_total++;
    if (got.size() != 3) $display("FAIL stream_count got=%0d exp=3", got.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= got.size() || got[i] != exp_v[i])
        $display("FAIL stream_out[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : -999, exp_v[i]);
      else n_pass++;
    end
    if (got_cyc.size() == 3) begin
      n_total++;
      if (got_cyc[0] - acc_cyc != 4) $display("FAIL stream_latency got=%0d exp=4", got_cyc[0] - acc_cyc);
      else n_pass++;
      n_total++;
      if (got_cyc[2] - got_cyc[0] != 2) $display("FAIL stream_consecutive got=%0d exp=2", got_cyc[2] - got_cyc[0]);
      else n_pass++;
    end
  endtask

  // Consumer stalls 6 cycles: four vectors fill the pipe, then everything drains in order.
  task automatic test_backpressure();
    int idx = 0;
    int t = 0;
    logic fed;
    logic [3:0] wes;
    got.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.a_valid = (idx < 8);
      set_a(idx + 1, 0, 0, 0);
      settle();
      fed = a_we;
      tick();
      if (fed) idx++;
    end
    bus.a_valid = 1'b1;
    set_a(idx + 1, 0, 0, 0);
    settle();
    wes = {a_we, r1_we, r2_we, r3_we};
    n_total++;
    if (idx != 4) $display("FAIL bp_fill_depth got=%0d exp=4", idx);
    else n_pass++;
    n_total++;
    if (bus.a_ready !== 1'b0) $display("FAIL bp_a_ready got=%b exp=0", bus.a_ready);
    else n_pass++;
    n_total++;
    if (wes !== 4'b0) $display("FAIL bp_frozen_we got=%b exp=0000", wes);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b1;
    while (got.size() < 8 && t < 40) begin
      bus.a_valid = (idx < 8);
      set_a(idx + 1, 0, 0, 0);
      settle();
      fed = a_we;
      tick();
      if (fed) idx++;
      t++;
    end
    bus.a_valid = 1'b0;
    repeat (3) tick();
    n_total++;
    if (got.size() != 8) $display("FAIL bp_count got=%0d exp=8", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (i >= got.size() || got[i] != i + 1)
        $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : -999, i + 1);
      else n_pass++;
    end
  endtask

  // New weights (2,2,2,2) arrive with three vectors in flight.
  task automatic test_weight_reload();
    int exp_v [4] = '{10, 2, 3, 8};
    int rise_cyc = 0;
    int we_cyc = -1;
    int t = 0;
    got.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.a_valid = 1'b1;
      if (k == 0) set_a(1, 1, 1, 1);
      else if (k == 1) set_a(0, 1, 0, 0);
      else set_a(0, 0, 1, 0);
      settle();
      n_total++;
      if (a_we !== 1'b1) $display("FAIL reload_pre_a_we[%0d] got=%b exp=1", k, a_we);
      else n_pass++;
      tick();
    end
    set_a(1, 1, 1, 1);
    bus.w_valid = 1'b1;
    set_w(2, 2, 2, 2);
    settle();
    rise_cyc = cyc;
    n_total++;
    if (bus.a_ready !== 1'b0) $display("FAIL reload_a_ready got=%b exp=0", bus.a_ready);
    else n_pass++;
    n_total++;
    if (w_we !== 1'b0) $display("FAIL reload_early_w_we got=%b exp=0", w_we);
    else n_pass++;
    tick();
    while (we_cyc < 0 && t < 10) begin
      settle();
      if (w_we) we_cyc = cyc;
      tick();
      t++;
    end
    bus.w_valid = 1'b0;
    n_total++;
    if (we_cyc - rise_cyc != 3) $display("FAIL reload_w_we_delay got=%0d exp=3", we_cyc - rise_cyc);
    else n_pass++;
    settle();
    n_total++;
    if (a_we !== 1'b1) $display("FAIL reload_post_a_we got=%b exp=1", a_we);
    else n_pass++;
    tick();
    bus.a_valid = 1'b0;
    t = 0;
    while (got.size() < 4 && t < 20) begin
      tick();
      t++;
    end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= got.size() || got[i] != exp_v[i])
        $display("FAIL reload_out[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : -999, exp_v[i]);
      else n_pass++;
    end
  endtask

  // Flush a full pipe; weights (2,2,2,2) must survive.
  task automatic test_flush();
    int t = 0;
    logic [4:0] wes;
    got.delete();
    bus.out_ready = 1'b0;
    bus.a_valid = 1'b1;
    set_a(5, 0, 0, 0);
    repeat (5) begin
      settle();
      tick();
    end
    flush = 1'b1;
    settle();
    wes = {w_we, a_we, r1_we, r2_we, r3_we};
    n_total++;
    if (wes !== 5'b0) $display("FAIL flush_we got=%b exp=00000", wes);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL flush_full got=%b exp=1", bus.out_valid);
    else n_pass++;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_a(1, 1, 1, 1);
    settle();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.a_ready !== 1'b1) $display("FAIL flush_a_ready got=%b exp=1", bus.a_ready);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy);
    else n_pass++;
    tick();
    bus.a_valid = 1'b0;
    while (got.size() < 1 && t < 20) begin
      tick();
      t++;
    end
    repeat (3) tick();
    n_total++;
    if (got.size() != 1 || got[0] != 8)
      $display("FAIL flush_weights_kept got=%0d (n=%0d) exp=8 (n=1)", (got.size() > 0) ? got[0] : -999, got.size());
    else n_pass++;
  endtask

`ifdef PLU_CTRL_PERF_EN
  // Five results with three stall cycles; the CNT_W=2 copy saturates its result count.
  task automatic test_perf();
    int idx = 0;
    int stalls = 0;
    int t = 0;
    logic fed;
    do_reset();
    settle();
    n_total++;
    if (result_cnt !== 16'd0 || stall_cnt !== 16'd0)
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", result_cnt, stall_cnt);
    else n_pass++;
    bus.w_valid = 1'b1;
    set_w(1, 2, 3, 4);
    tick();
    bus.w_valid = 1'b0;
    while (got.size() < 5 && t < 60) begin
      bus.a_valid = (idx < 5);
      set_a(idx + 1, 0, 0, 0);
      bus.out_ready = 1'b1;
      settle();
      if (bus.out_valid && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
        settle();
      end
      fed = a_we;
      tick();
      if (fed) idx++;
      t++;
    end
    bus.a_valid = 1'b0;
    n_total++;
    if (result_cnt !== 16'd5) $display("FAIL perf_result_cnt got=%0d exp=5", result_cnt);
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd3) $display("FAIL perf_stall_cnt got=%0d exp=3", stall_cnt);
    else n_pass++;
    n_total++;
    if (sat_result_cnt !== 2'd3) $display("FAIL perf_sat_result got=%0d exp=3", sat_result_cnt);
    else n_pass++;
    n_total++;
    if (sat_stall_cnt !== 2'd3) $display("FAIL perf_sat_stall got=%0d exp=3", sat_stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_weight_reload();
    test_flush();
`ifdef PLU_CTRL_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
